instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Program-issue initiator for the processor's Run/Done handshake.
//  Fetches instruction words from a synchronous program ROM and drives each one on DIN.
//  Pulses Run once per word, then waits for the processor's Done before issuing the next word.
//  Sits between the program ROM and the processor; replaces free-running address counters in the MCU top.
// PARAMETERS
//  DATA_W    16  width of instruction word / DIN
//  ADDR_W     5  ROM address width; pc width
//  PROG_LEN  24  number of words to issue (1..2**ADDR_W)
//  TIMEOUT   64  max Pclk cycles waiting for Done (used only with SEQ_TIMEOUT_EN)
// PORTS
//  Pclk      in   1       single clock, all logic on rising edge
//  Reset     in   1       asynchronous, active-high
//  Start     in   1       begin issuing from pc=0 (sampled in IDLE/FIN)
//  Abort     in   1       synchronous stop, return to IDLE
//  rom_addr  out  ADDR_W  ROM address (= pc, combinational)
//  rom_data  in   DATA_W  ROM read data, valid 1 cycle after rom_addr
//  DIN       out  DATA_W  instruction word to processor (registered)
//  Run       out  1       1-cycle issue pulse to processor
//  Done      in   1       processor completion pulse
//  pc        out  ADDR_W  index of word in flight
//  Busy      out  1       high from FETCH through WAIT_DONE
//  Finished  out  1       high in FIN
//  Error     out  1       sticky timeout flag
// BEHAVIOUR
//  Reset: state=IDLE; pc=0, DIN=0, Run=0, Busy=0, Finished=0, Error=0.
//  States: IDLE, FETCH, ISSUE, WAIT_DONE, FIN, ERR.
//   IDLE      : Start=1 -> pc<=0, FETCH.
//   FETCH     : ROM read of pc in progress -> ISSUE.
//   ISSUE     : DIN<=rom_data, Run=1 for this cycle only -> WAIT_DONE.
//   WAIT_DONE : DIN held. Done=1 and pc==PROG_LEN-1 -> FIN; Done=1 otherwise -> pc<=pc+1, FETCH.
//   FIN       : Finished=1, DIN held; Start=1 -> pc<=0, FETCH.
//   ERR       : Error=1; only Reset or Abort leaves.
//  Latency: Start sampled at edge N -> Run high in cycle N+2, DIN valid in the same cycle.
//  Done -> next Run: exactly 3 cycles (WAIT_DONE->FETCH->ISSUE).
//  Done outside WAIT_DONE (incl. same cycle as Run) is ignored.
//  Run never high in two consecutive cycles.
//  Abort: overrides Start/Done. Next state IDLE, pc<=0, Run=0, Error cleared; DIN keeps last value.
//  Start while Busy: ignored.
//  pc never wraps; last issued index is PROG_LEN-1.
//  Reset mid-operation: immediate return to reset values; in-flight Done is lost.
// CONFIGURATION
//  SEQ_TIMEOUT_EN defined:
//   - Counter clears on entry to WAIT_DONE.
//   - TIMEOUT cycles without Done -> ERR; Error=1, Busy=0.
//  SEQ_TIMEOUT_EN undefined:
//   - No counter; WAIT_DONE waits indefinitely.
//   - Error tied 0; ERR unreachable.
// TESTING
//  1 Reset=1 mid-run -> all outputs 0, state IDLE on next edge, pc=0.
//  2 ROM[i]=16'h0100+i, Start pulse, Done 4 cycles after each Run:
//    -> 24 Run pulses, DIN=0100..0117 in order, Finished=1 after 24th Done.
//  3 Start at edge N -> Run=1 at N+2.
//    Done at edge M -> next Run at M+3.
//    Done asserted in Run cycle -> ignored.
//  4 Abort during WAIT_DONE at pc=7 -> IDLE, pc=0, no further Run.
//    Start -> restarts at ROM[0].
//  5 SEQ_TIMEOUT_EN, TIMEOUT=8, Done withheld -> Error=1 exactly 8 cycles after entering WAIT_DONE.
//    Without macro -> Busy stays 1, Error=0.
//  6 Start in FIN -> second full pass identical to first.
//    Start while Busy -> no effect on pc or Run.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: issues PROG_LEN words from a synchronous program ROM to a
//   processor over a Run/Done handshake, one word in flight at a time.
// Latency: Start sampled -> Run high two edges later (IDLE->FETCH->ISSUE), DIN
//   valid in the same cycle as Run; Done sampled -> next Run two edges later.
// Backpressure: nothing new is issued until the processor returns Done; with
//   SEQ_TIMEOUT_EN defined, TIMEOUT cycles without Done parks the block in ERR.
// Ports: Pclk/Reset (async, active-high); Start/Abort control; rom_addr/rom_data
//   ROM port (data one cycle after address); DIN/Run/Done processor handshake;
//   pc, Busy, Finished, Error status.
module instr_sequencer #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int PROG_LEN = 24,
  parameter int TIMEOUT  = 64
) (
  input  logic              Pclk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  input  logic              Done,
  output logic [ADDR_W-1:0] pc,
  output logic              Busy,
  output logic              Finished,
  output logic              Error
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT_DONE, S_FIN, S_ERR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              run_q, run_d;

`ifdef SEQ_TIMEOUT_EN
  localparam int          TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  // TIMEOUT only has meaning when the Done watchdog is built in.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    din_d   = din_q;
    run_d   = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    if (Abort) begin
      // DIN deliberately keeps its last value.
      state_d = S_IDLE;
      pc_d    = '0;
    end else begin
      case (state_q)
        S_IDLE, S_FIN: begin
          if (Start) begin
            pc_d    = '0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: state_d = S_ISSUE;
        S_ISSUE: begin
          // rom_data now holds ROM[pc]; DIN and Run are registered together
          // so the processor sees them in the same cycle.
          din_d   = rom_data;
          run_d   = 1'b1;
          state_d = S_WAIT_DONE;
`ifdef SEQ_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
        S_WAIT_DONE: begin
          // A Done coinciding with the Run pulse cannot belong to this word.
          if (Done && !run_q) begin
            if (pc_q == LAST_PC) begin
              state_d = S_FIN;
            end else begin
              pc_d    = pc_q + 1'b1;
              state_d = S_FETCH;
            end
          end
`ifdef SEQ_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            state_d = S_ERR;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
`endif
        end
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Pclk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      din_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      din_q   <= din_d;
      run_q   <= run_d;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge Pclk or posedge Reset) begin
    if (Reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
  assign Error = (state_q == S_ERR);
`else
  assign Error = 1'b0;
`endif

  assign rom_addr = pc_q;
  assign pc       = pc_q;
  assign DIN      = din_q;
  assign Run      = run_q;
  assign Busy     = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
                    (state_q == S_WAIT_DONE);
  assign Finished = (state_q == S_FIN);

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 5;
  localparam int PROG_LEN = 24;

  logic              Pclk = 1'b0;
  logic              Reset = 1'b1;
  logic              Start = 1'b0;
  logic              Abort = 1'b0;
  logic              Done = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data = '0;
  logic [DATA_W-1:0] DIN;
  logic              Run;
  logic [ADDR_W-1:0] pc;
  logic              Busy;
  logic              Finished;
  logic              Error;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] rom [32];

  instr_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PROG_LEN(PROG_LEN), .TIMEOUT(8)
  ) dut (
    .Pclk(Pclk), .Reset(Reset), .Start(Start), .Abort(Abort),
    .rom_addr(rom_addr), .rom_data(rom_data), .DIN(DIN), .Run(Run),
    .Done(Done), .pc(pc), .Busy(Busy), .Finished(Finished), .Error(Error)
  );

  always #5 Pclk = ~Pclk;

  // Synchronous program ROM: data one cycle after address.
  always @(posedge Pclk) rom_data <= rom[rom_addr];

  task automatic tick();
    @(posedge Pclk);
    #1;
  endtask

  // Advance until Run is seen or the budget runs out.
  task automatic wait_run(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      tick();
      if (Run === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic send_done(input int gap);
    repeat (gap) tick();
    Done = 1'b1;
    tick();
    Done = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) tick();
    checks++;
    if ({Run, Busy, Finished, Error, pc, DIN, rom_addr} !== '0) begin
      errors++;
      $display("FAIL reset_state: Run=%b Busy=%b Fin=%b Err=%b pc=%0d DIN=%h, required all 0",
               Run, Busy, Finished, Error, pc, DIN);
    end
    Reset = 1'b0;
    tick();
    checks++;
    if (Busy !== 1'b0 || Run !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: Busy=%b Run=%b, required 0 0", Busy, Run);
    end
  endtask

  task automatic test_full_pass(input int pass_no);
    bit seen;
    int runs = 0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < PROG_LEN; i++) begin
      wait_run(seen);
      if (seen) runs++;
      checks++;
      if (!seen || DIN !== DATA_W'(16'h0100 + i) || pc !== ADDR_W'(i)) begin
        errors++;
        $display("FAIL pass%0d_word%0d: seen=%b DIN=%h pc=%0d, required DIN=%h pc=%0d",
                 pass_no, i, seen, DIN, pc, 16'h0100 + i, i);
      end
      tick();
      checks++;
      if (Run !== 1'b0) begin
        errors++;
        $display("FAIL pass%0d_run_single%0d: Run=%b, required 0", pass_no, i, Run);
      end
      send_done(3);
    end
    checks++;
    if (Finished !== 1'b1 || Busy !== 1'b0 || runs != PROG_LEN) begin
      errors++;
      $display("FAIL pass%0d_finished: Fin=%b Busy=%b runs=%0d, required 1 0 %0d",
               pass_no, Finished, Busy, runs, PROG_LEN);
    end
    repeat (6) begin
      tick();
      if (Run === 1'b1) runs++;
    end
    checks++;
    if (runs != PROG_LEN || Finished !== 1'b1) begin
      errors++;
      $display("FAIL pass%0d_idle_in_fin: runs=%0d Fin=%b, required %0d 1",
               pass_no, runs, Finished, PROG_LEN);
    end
  endtask

  task automatic test_start_busy();
    bit seen;
    int extra = 0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_run(seen);
    Start = 1'b1;
    repeat (3) begin
      tick();
      if (Run === 1'b1) extra++;
    end
    Start = 1'b0;
    checks++;
    if (pc !== 0 || extra != 0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL start_while_busy: pc=%0d extra_runs=%0d Busy=%b, required 0 0 1",
               pc, extra, Busy);
    end
    send_done(0);
    wait_run(seen);
    checks++;
    if (!seen || pc !== 1 || DIN !== 16'h0101) begin
      errors++;
      $display("FAIL start_busy_next: seen=%b pc=%0d DIN=%h, required 1 1 0101", seen, pc, DIN);
    end
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
  endtask

  task automatic test_abort();
    bit seen;
    int extra = 0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_run(seen);
      if (i < 7) send_done(2);
    end
    checks++;
    if (!seen || pc !== 7 || DIN !== 16'h0107) begin
      errors++;
      $display("FAIL abort_setup: seen=%b pc=%0d DIN=%h, required 1 7 0107", seen, pc, DIN);
    end
    tick();
    Abort = 1'b1;
    Done = 1'b1;
    tick();
    Abort = 1'b0;
    Done = 1'b0;
    checks++;
    if (Busy !== 1'b0 || pc !== 0 || Run !== 1'b0 || DIN !== 16'h0107 || Finished !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: Busy=%b pc=%0d Run=%b DIN=%h Fin=%b, required 0 0 0 0107 0",
               Busy, pc, Run, DIN, Finished);
    end
    repeat (10) begin
      tick();
      if (Run === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_run: runs=%0d Busy=%b, required 0 0", extra, Busy);
    end
    Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_run(seen);
    checks++;
    if (!seen || pc !== 0 || DIN !== 16'h0100) begin
      errors++;
      $display("FAIL abort_restart: seen=%b pc=%0d DIN=%h, required 1 0 0100", seen, pc, DIN);
    end
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
  endtask

  task automatic test_latency();
    int stray = 0;
    Start = 1'b1;
    tick();                        // edge N samples Start
    Start = 1'b0;
    checks++;
    if (Run !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL lat_n: Run=%b Busy=%b, required 0 1", Run, Busy);
    end
    tick();                        // N+1
    checks++;
    if (Run !== 1'b0) begin
      errors++;
      $display("FAIL lat_n1: Run=%b, required 0", Run);
    end
    tick();                        // N+2
    checks++;
    if (Run !== 1'b1 || DIN !== 16'h0100) begin
      errors++;
      $display("FAIL lat_n2: Run=%b DIN=%h, required 1 0100", Run, DIN);
    end
    Done = 1'b1;                   // Done in the Run cycle must be ignored
    tick();
    Done = 1'b0;
    repeat (3) begin
      if (Run === 1'b1) stray++;
      tick();
    end
    checks++;
    if (stray != 0 || pc !== 0 || Busy !== 1'b1 || Run !== 1'b0) begin
      errors++;
      $display("FAIL done_in_run_ignored: runs=%0d pc=%0d Busy=%b Run=%b, required 0 0 1 0",
               stray, pc, Busy, Run);
    end
    Done = 1'b1;                   // raised at edge M
    tick();                        // M+1 samples Done
    Done = 1'b0;
    checks++;
    if (Run !== 1'b0) begin
      errors++;
      $display("FAIL lat_m1: Run=%b, required 0", Run);
    end
    tick();                        // M+2
    checks++;
    if (Run !== 1'b0) begin
      errors++;
      $display("FAIL lat_m2: Run=%b, required 0", Run);
    end
    tick();                        // M+3
    checks++;
    if (Run !== 1'b1 || DIN !== 16'h0101 || pc !== 1) begin
      errors++;
      $display("FAIL lat_m3: Run=%b DIN=%h pc=%0d, required 1 0101 1", Run, DIN, pc);
    end
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
  endtask

  task automatic test_timeout();
    bit seen;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_run(seen);                // first WAIT_DONE cycle
`ifdef SEQ_TIMEOUT_EN
    repeat (7) tick();
    checks++;
    if (!seen || Error !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: seen=%b Err=%b Busy=%b, required 1 0 1", seen, Error, Busy);
    end
    tick();
    checks++;
    if (Error !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_at_8: Err=%b Busy=%b, required 1 0", Error, Busy);
    end
    Start = 1'b1;
    Done = 1'b1;
    repeat (2) tick();
    Start = 1'b0;
    Done = 1'b0;
    checks++;
    if (Error !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky: Err=%b Busy=%b, required 1 0", Error, Busy);
    end
`else
    repeat (20) tick();
    checks++;
    if (!seen || Error !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL no_timeout: seen=%b Err=%b Busy=%b, required 1 0 1", seen, Error, Busy);
    end
`endif
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    checks++;
    if (Error !== 1'b0 || Busy !== 1'b0 || pc !== 0) begin
      errors++;
      $display("FAIL abort_clears: Err=%b Busy=%b pc=%0d, required 0 0 0", Error, Busy, pc);
    end
  endtask

  task automatic test_reset_midrun();
    bit seen;
    int stray = 0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_run(seen);
    send_done(1);
    wait_run(seen);
    Done = 1'b1;                   // in flight when Reset hits
    #1 Reset = 1'b1;
    #1;
    checks++;
    if ({Run, Busy, Finished, Error, pc, DIN, rom_addr} !== '0) begin
      errors++;
      $display("FAIL reset_midrun: Run=%b Busy=%b Fin=%b Err=%b pc=%0d DIN=%h, required all 0",
               Run, Busy, Finished, Error, pc, DIN);
    end
    tick();
    Reset = 1'b0;
    tick();
    Done = 1'b0;
    repeat (5) begin
      tick();
      if (Run === 1'b1) stray++;
    end
    checks++;
    if (stray != 0 || Busy !== 1'b0 || pc !== 0) begin
      errors++;
      $display("FAIL reset_done_lost: runs=%0d Busy=%b pc=%0d, required 0 0 0", stray, Busy, pc);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = DATA_W'(16'h0100 + i);
    test_reset();
    test_full_pass(1);
    test_full_pass(2);
    test_start_busy();
    test_abort();
    test_latency();
    test_timeout();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
